// File: rtl/freq_meter_pkg.sv
// Shared state encoding and parameter helpers for the freq_meter block.
package freq_meter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE    = 1'b0;
  localparam state_t MEASURE = 1'b1;

  function automatic int gate_cycles(input int frequency_in, input int gate_hz);
    return frequency_in / gate_hz;
  endfunction

  // Wide enough for count * gate_hz without truncation.
  function automatic int freq_width(input int count_width, input int gate_hz);
    return count_width + $clog2(gate_hz + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge detector.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Level,
  output logic Rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: synchronizer flops take the reset so no stale level can fake an edge after reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], In};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign Level = sync_q[SYNC_STAGES-1];
  assign Rise  = Level & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gate-window frequency meter with a valid/ready result interface.
// Define FREQ_METER_DUTY_EN to add the HighCycles duty-cycle output.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int   FREQUENCY_IN = 50_000_000,
  parameter int   GATE_HZ      = 10,
  parameter int   COUNT_WIDTH  = 24,
  parameter int   SYNC_STAGES  = 2,
  localparam int  GATE_CYCLES  = gate_cycles(FREQUENCY_IN, GATE_HZ),
  localparam int  FREQ_WIDTH   = freq_width(COUNT_WIDTH, GATE_HZ)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic                   SignalIn,
  output logic [FREQ_WIDTH-1:0]  Frequency,
  output logic [COUNT_WIDTH-1:0] EdgeCount,
  output logic                   ResultValid,
  input  logic                   ResultReady,
  output logic                   Saturated,
  output logic                   Overrun
`ifdef FREQ_METER_DUTY_EN
  ,
  output logic [$clog2(GATE_CYCLES+1)-1:0] HighCycles
`endif
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  if (GATE_CYCLES < 2) begin : g_gate_len_check
    $error("freq_meter: GATE_CYCLES must be at least 2");
  end
  if (FREQUENCY_IN % GATE_HZ != 0) begin : g_gate_div_check
    $error("freq_meter: FREQUENCY_IN must be a multiple of GATE_HZ");
  end
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("freq_meter: SYNC_STAGES must be at least 2");
  end

  state_t                   state_q;
  logic [GATE_W-1:0]        gate_cnt_q;
  logic [COUNT_WIDTH-1:0]   edge_cnt_q;
  logic [COUNT_WIDTH-1:0]   edge_cnt_next;
  logic                     sat_q;
  logic                     sat_next;
  logic                     sig_level;
  logic                     sig_rise;
  logic                     counting;
  logic                     gate_done;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clk  (Clk),
    .Reset(Reset),
    .In   (SignalIn),
    .Level(sig_level),
    .Rise (sig_rise)
  );

  // The terminal cycle's edge is folded into edge_cnt_next, so the loaded count includes it.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    edge_cnt_next = edge_cnt_q;
    if (sig_rise && (edge_cnt_q != COUNT_MAX)) begin
      edge_cnt_next = edge_cnt_q + COUNT_WIDTH'(1);
    end
    sat_next = sat_q | (edge_cnt_next == COUNT_MAX);
  end

  assign counting  = (state_q == MEASURE) && Enable;
  assign gate_done = counting && (gate_cnt_q == GATE_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= Enable ? MEASURE : IDLE;
        default: state_q <= Enable ? MEASURE : IDLE;
      endcase
      // Counters clear both on gate completion (next gate starts at once) and on abort.
      if (counting && !gate_done) begin
        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
        edge_cnt_q <= edge_cnt_next;
        sat_q      <= sat_next;
      end else begin
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
        sat_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ResultValid <= 1'b0;
      EdgeCount   <= '0;
      Frequency   <= '0;
      Saturated   <= 1'b0;
      Overrun     <= 1'b0;
    end else if (gate_done) begin
      ResultValid <= 1'b1;
      EdgeCount   <= edge_cnt_next;
      Frequency   <= FREQ_WIDTH'(edge_cnt_next) * FREQ_WIDTH'(GATE_HZ);
      Saturated   <= sat_next;
      Overrun     <= ResultValid && !ResultReady;
    end else if (ResultValid && ResultReady) begin
      ResultValid <= 1'b0;
    end
  end

`ifdef FREQ_METER_DUTY_EN
  localparam int HIGH_WIDTH = $clog2(GATE_CYCLES + 1);

  logic [HIGH_WIDTH-1:0] high_cnt_q;
  logic [HIGH_WIDTH-1:0] high_cnt_next;

  assign high_cnt_next = high_cnt_q + HIGH_WIDTH'(sig_level);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      high_cnt_q <= '0;
      HighCycles <= '0;
    end else begin
      high_cnt_q <= (counting && !gate_done) ? high_cnt_next : '0;
      if (gate_done) begin
        HighCycles <= high_cnt_next;
      end
    end
  end
`else
  // The synchronized level only feeds the duty counter.
  logic level_unused;
  assign level_unused = sig_level;
`endif

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an asynchronous input signal against the system clock Clk.
- Counts synchronized rising edges of SignalIn over a fixed gate window derived from FREQUENCY_IN, then reports the result in Hz through a valid/ready handshake.
- Complements the divider blocks: it verifies generated clocks and clock enables on-chip, and measures external clock or tach inputs.

Parameters:
- FREQUENCY_IN, 50_000_000, Clk frequency in Hz.
- GATE_HZ, 10, gate windows per second; gate length GATE_CYCLES = FREQUENCY_IN / GATE_HZ Clk cycles.
- COUNT_WIDTH, 24, edge counter width.
- SYNC_STAGES, 2, flip-flops in the SignalIn synchronizer (minimum 2).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- Enable  in  1  level; 1 = measure continuously.
- SignalIn  in  1  asynchronous signal to measure.
- Frequency  out  FREQ_WIDTH  measured Hz; FREQ_WIDTH = COUNT_WIDTH + $clog2(GATE_HZ+1).
- EdgeCount  out  COUNT_WIDTH  raw edges in the last gate.
- ResultValid  out  1  result held and available.
- ResultReady  in  1  consumer accepts the result when ResultValid && ResultReady.
- Saturated  out  1  the reported gate hit the counter maximum.
- Overrun  out  1  the reported result overwrote an unconsumed one.

Behaviour:
- Interface: reset Reset, synchronous, active-low; clock Clk. All state is updated on posedge Clk only.
- Reset values: all outputs are 0; state is IDLE; counters are 0; synchronizer flops are 0.
- Elaboration errors:
  - GATE_CYCLES < 2.
  - FREQUENCY_IN % GATE_HZ != 0.
  - SYNC_STAGES < 2.
- Synchronizer and edge detector:
  - Run every cycle regardless of Enable.
  - Edge = sync_out & ~sync_prev.
  - Latency from a SignalIn rise to the counted edge is SYNC_STAGES+1 cycles, ±1 for metastability.
- Measurable input: at most FREQUENCY_IN/2 Hz. Faster inputs alias; this is not flagged.
- FSM states:
  - IDLE: GateCnt = 0, EdgeCnt = 0. Enable = 1 moves to MEASURE next cycle.
  - MEASURE:
    - GateCnt increments from 0 to GATE_CYCLES-1.
    - EdgeCnt increments on each Edge and saturates at 2^COUNT_WIDTH-1, setting an internal sat bit.
    - Terminal cycle (GateCnt == GATE_CYCLES-1): an edge in this cycle is counted. Next cycle the final count is loaded into the result registers, GateCnt, EdgeCnt and sat clear, and the next gate starts immediately. There are no dead cycles.
    - Enable = 0 in any cycle: next state is IDLE and the partial gate is discarded. A held result is untouched.
- Result registers:
  - On load: EdgeCount = count, Frequency = count * GATE_HZ (constant multiply, no truncation), Saturated = sat.
  - Overrun = 1 if ResultValid was 1 and no accept occurred in the load cycle; else 0.
  - ResultValid = 1.
- Handshake:
  - ResultValid stays high until accepted.
  - Accept with no simultaneous load: ResultValid = 0 next cycle; data stays stable.
  - Accept in the same cycle as a load: the new result loads, ResultValid stays 1, Overrun = 0.
  - Outputs must not change while ResultValid = 1 except on a load.
- Reset mid-gate or mid-handshake: everything returns to reset values next cycle.

Optional Feature:
- Macro FREQ_METER_DUTY_EN.
- Defined:
  - Adds output HighCycles [$clog2(GATE_CYCLES+1)-1:0], the count of gate cycles with sync_out = 1.
  - Loaded with the other result fields and following the same handshake.
  - Saturation is impossible by width.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package freq_meter_pkg:
  - State enum (IDLE, MEASURE).
  - Helper functions for GATE_CYCLES and FREQ_WIDTH.
- Sub-module sync_edge_detect:
  - Parameter SYNC_STAGES.
  - Ports Clk, Reset, In, Level, Rise.
  - Reusable by other blocks that take async inputs.

Test Plan (FREQUENCY_IN = 1000, GATE_HZ = 10, so GATE_CYCLES = 100; COUNT_WIDTH = 8 unless noted):
- SignalIn toggles every 5 cycles, Enable = 1, ResultReady = 1:
  - Each result has EdgeCount = 10 and Frequency = 100.
  - ResultValid pulses 1 cycle every 100 cycles.
  - Saturated = 0, Overrun = 0.
- SignalIn constant 0, then constant 1: EdgeCount = 0, Frequency = 0. A single 0→1 step yields exactly 1 edge in its gate.
- COUNT_WIDTH = 4, SignalIn toggles every cycle (50 edges per gate): EdgeCount = 15, Frequency = 150, Saturated = 1.
- ResultReady = 0 across two gates:
  - The first result is held stable.
  - At the second load, data updates and Overrun = 1.
  - Asserting ResultReady for 1 cycle drops ResultValid next cycle.
- Enable dropped at GateCnt = 50, then re-raised: no result from the partial gate. The first result appears 100 cycles + 1 after re-entering MEASURE, with the correct count.
- Reset asserted mid-gate while ResultValid = 1: next cycle all outputs are 0 and the FSM is in IDLE. With FREQ_METER_DUTY_EN defined, 50% duty input gives HighCycles = 50.
